// File: rtl/cyclic_lamp.sv
// -----------------------------------------------------------------------------
// cyclic_lamp
//   Free-running three-colour lamp sequencer. Shows exactly one of Red, Green
//   or Yellow at a time and cycles R -> G -> Y -> R. Each colour is held for
//   its own programmable number of clock cycles. A dwell of 0 is treated as 1.
//
// Parameters
//   RED_CYCLES     cycles Red is held per period
//   GREEN_CYCLES   cycles Green is held per period
//   YELLOW_CYCLES  cycles Yellow is held per period
//
// Ports
//   clk     in   1      single clock, all state changes on its rising edge
//   rst_n   in   1      synchronous active-low reset. It forces Red and
//                       clears the dwell counter.
//   light   out  [0:2]  one-hot lamp vector, light[0]=Red, light[1]=Green,
//                       light[2]=Yellow. It is driven directly by a flop.
// -----------------------------------------------------------------------------
module cyclic_lamp #(
  parameter int unsigned RED_CYCLES    = 1,
  parameter int unsigned GREEN_CYCLES  = 1,
  parameter int unsigned YELLOW_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [0:2] light
);

  // Effective dwells: a zero dwell would never match the counter, so clamp to 1.
  localparam int unsigned RED_DW    = (RED_CYCLES    == 0) ? 1 : RED_CYCLES;
  localparam int unsigned GREEN_DW  = (GREEN_CYCLES  == 0) ? 1 : GREEN_CYCLES;
  localparam int unsigned YELLOW_DW = (YELLOW_CYCLES == 0) ? 1 : YELLOW_CYCLES;

  localparam int unsigned MAX_RG = (RED_DW > GREEN_DW) ? RED_DW : GREEN_DW;
  localparam int unsigned MAX_DW = (MAX_RG > YELLOW_DW) ? MAX_RG : YELLOW_DW;
  localparam int unsigned CNT_W  = $clog2(MAX_DW) + 1;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_DW - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_DW - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_DW - 1);

  // Plain 2-bit codes rather than an enum: the fourth code 2'b11 is a real,
  // reachable value (for example at power-up), and it must be recovered from.
  localparam logic [1:0] S_RED    = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;

  localparam logic [0:2] L_RED    = 3'b100;
  localparam logic [0:2] L_GREEN  = 3'b010;
  localparam logic [0:2] L_YELLOW = 3'b001;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:2]       light_q, light_d;

  // State register. Reset is sampled on the clock edge and overrides sequencing.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values;
  // blocking ones would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RED;
      cnt_q   <= '0;
      light_q <= L_RED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      light_q <= light_d;
    end
  end

  // Next-state logic. ">=" rather than "==" behaves the same for every
  // reachable count. It also stops a garbage power-up count from stalling the
  // lamp until the counter wraps.
  // NOTE: every output of this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      S_RED: begin
        if (cnt_q >= RED_LAST) begin
          state_d = S_GREEN;
          cnt_d   = '0;
        end
      end
      S_GREEN: begin
        if (cnt_q >= GREEN_LAST) begin
          state_d = S_YELLOW;
          cnt_d   = '0;
        end
      end
      S_YELLOW: begin
        if (cnt_q >= YELLOW_LAST) begin
          state_d = S_RED;
          cnt_d   = '0;
        end
      end
      default: begin
        // Illegal encoding: restart a clean Red dwell.
        state_d = S_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state. The lamp flop then changes in the same
  // edge as the state, so light mirrors the current state with no decode glitch.
  always_comb begin
    light_d = L_RED;
    case (state_d)
      S_GREEN:  light_d = L_GREEN;
      S_YELLOW: light_d = L_YELLOW;
      default:  light_d = L_RED;
    endcase
  end

  assign light = light_q;

endmodule

// File: tb/tb_cyclic_lamp.sv
// -----------------------------------------------------------------------------
// tb_cyclic_lamp
//   Three instances share one clock and one reset:
//     dut 0: default dwells (1,1,1)
//     dut 1: dwells R=3, G=2, Y=1
//     dut 2: zero Green dwell (1,0,1)
//
//   The model tracks each lamp as a position inside its period, from 0 to
//   period-1. A reset edge or an illegal-state recovery sets the position to
//   0, and every other edge advances it modulo the period. The expected colour
//   comes from the position and the cumulative dwells. Literal sequences pin
//   the model against hand-derived values.
// -----------------------------------------------------------------------------
module tb_cyclic_lamp;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:2] l_def, l_dw, l_zd;

  always #5 clk = ~clk;

  cyclic_lamp u_def (
    .clk   (clk),
    .rst_n (rst_n),
    .light (l_def)
  );

  cyclic_lamp #(.RED_CYCLES(3), .GREEN_CYCLES(2), .YELLOW_CYCLES(1)) u_dw (
    .clk   (clk),
    .rst_n (rst_n),
    .light (l_dw)
  );

  cyclic_lamp #(.RED_CYCLES(1), .GREEN_CYCLES(0), .YELLOW_CYCLES(1)) u_zd (
    .clk   (clk),
    .rst_n (rst_n),
    .light (l_zd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int dr[3] = '{1, 3, 1};
  int dg[3] = '{1, 2, 0};
  int dy[3] = '{1, 1, 1};

  int t[3]         = '{0, 0, 0};
  bit valid[3]     = '{1'b0, 1'b0, 1'b0};
  bit force_req[3] = '{1'b0, 1'b0, 1'b0};

  logic [2:0] exp_def[6] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100};
  logic [2:0] exp_dw[6]  = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b100};
  logic [2:0] exp_zd[6]  = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100};

  function automatic int eff(input int x);
    return (x < 1) ? 1 : x;
  endfunction

  function automatic int period(input int k);
    return eff(dr[k]) + eff(dg[k]) + eff(dy[k]);
  endfunction

  function automatic logic [2:0] model_light(input int k);
    int r = eff(dr[k]);
    int g = eff(dg[k]);
    if (t[k] < r)     return 3'b100;
    if (t[k] < r + g) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] dut_light(input int k);
    case (k)
      0:       return l_def;
      1:       return l_dw;
      default: return l_zd;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One rising edge. Advance the model at the edge, then compare every DUT at
  // the following falling edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || force_req[k]) begin
        t[k]     = 0;
        valid[k] = 1'b1;
      end else if (valid[k]) begin
        t[k] = (t[k] + 1) % period(k);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (valid[k]) begin
        check($sformatf("model_dut%0d", k), int'(dut_light(k)), int'(model_light(k)));
        check($sformatf("onehot_dut%0d", k), $countones(dut_light(k)), 1);
      end
    end
  endtask

  // Plant the illegal code 2'b11 in one instance's state register, then let
  // one edge recover it.
  task automatic do_illegal(input int k);
    case (k)
      0:       force u_def.state_q = 2'b11;
      1:       force u_dw.state_q  = 2'b11;
      default: force u_zd.state_q  = 2'b11;
    endcase
    #1;
    case (k)
      0:       release u_def.state_q;
      1:       release u_dw.state_q;
      default: release u_zd.state_q;
    endcase
    force_req[k] = 1'b1;
    tick();
    force_req[k] = 1'b0;
    check($sformatf("illegal_dut%0d", k), int'(dut_light(k)), 3'b100);
  endtask

  initial begin
    // Reset held for two edges: Red after the first edge and while low.
    rst_n = 1'b0;
    tick();
    check("rst_edge1_def", int'(l_def), 3'b100);
    check("rst_edge1_dw",  int'(l_dw),  3'b100);
    tick();
    check("rst_edge2_zd",  int'(l_zd),  3'b100);

    // Release: literal sequences per instance.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("seq_def_%0d", i), int'(l_def), int'(exp_def[i]));
      check($sformatf("seq_dw_%0d", i),  int'(l_dw),  int'(exp_dw[i]));
      check($sformatf("seq_zd_%0d", i),  int'(l_zd),  int'(exp_zd[i]));
    end

    // Run into the first Green cycle of dut 1, which still has dwell left.
    for (int n = 0; n < 20 && t[1] != 3; n++) tick();
    check("mid_green_dw", int'(l_dw), 3'b010);

    // Mid-dwell reset, then a full three-cycle Red.
    rst_n = 1'b0;
    tick();
    check("midrst_dw", int'(l_dw), 3'b100);
    rst_n = 1'b1;
    tick();
    check("midrst_red2_dw", int'(l_dw), 3'b100);
    tick();
    check("midrst_red3_dw", int'(l_dw), 3'b100);
    tick();
    check("midrst_green_dw", int'(l_dw), 3'b010);

    // Illegal-state recovery for each instance. Dut 1 is Green here.
    do_illegal(1);
    tick();
    tick();
    tick();
    check("illegal_resume_dw", int'(l_dw), 3'b010);
    do_illegal(0);
    tick();
    check("illegal_resume_def", int'(l_def), 3'b010);
    do_illegal(2);
    tick();
    check("illegal_resume_zd", int'(l_zd), 3'b010);

    // Free run across several periods of every instance.
    repeat (15) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
